// File: rtl/memory_driver.sv
// Responder for the engine memory-request interface: turns each accepted request
// into one single-beat AXI4 read or write on the node RAM, one request at a time.
module memory_driver #(
  parameter int RAM_DATA_WIDTH = 32,
  parameter int RAM_ADDR_WIDTH = 16,
  parameter int RAM_STRB_WIDTH = RAM_DATA_WIDTH / 8,
  parameter int RAM_ID_WIDTH   = 8
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic                      mem_valid,
  output logic                      mem_ready,
  input  logic                      mem_rd,
  input  logic                      mem_wr,
  input  logic [RAM_ADDR_WIDTH-1:0] mem_addr,
  input  logic [RAM_DATA_WIDTH-1:0] mem_wr_data,
  output logic                      mem_rd_valid,
  input  logic                      mem_rd_ready,
  output logic [RAM_DATA_WIDTH-1:0] mem_rd_data,
  output logic                      err,
  output logic                      awvalid,
  input  logic                      awready,
  output logic [RAM_ADDR_WIDTH-1:0] awaddr,
  output logic [RAM_ID_WIDTH-1:0]   awid,
  output logic [7:0]                awlen,
  output logic [2:0]                awsize,
  output logic [1:0]                awburst,
  output logic                      wvalid,
  input  logic                      wready,
  output logic [RAM_DATA_WIDTH-1:0] wdata,
  output logic [RAM_STRB_WIDTH-1:0] wstrb,
  output logic                      wlast,
  input  logic                      bvalid,
  output logic                      bready,
  input  logic [RAM_ID_WIDTH-1:0]   bid,
  input  logic [1:0]                bresp,
  output logic                      arvalid,
  input  logic                      arready,
  output logic [RAM_ADDR_WIDTH-1:0] araddr,
  output logic [RAM_ID_WIDTH-1:0]   arid,
  output logic [7:0]                arlen,
  output logic [2:0]                arsize,
  output logic [1:0]                arburst,
  input  logic                      rvalid,
  output logic                      rready,
  input  logic [RAM_ID_WIDTH-1:0]   rid,
  input  logic [RAM_DATA_WIDTH-1:0] rdata,
  input  logic [1:0]                rresp,
  input  logic                      rlast
);

  localparam logic [2:0] AX_SIZE = 3'($clog2(RAM_STRB_WIDTH));

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RD_CPL} state_t;

  state_t                    state;
  logic [RAM_ADDR_WIDTH-1:0] addr_q;
  logic [RAM_DATA_WIDTH-1:0] wdata_q;
  logic                      aw_done;
  logic                      w_done;
  logic                      unused_inputs;

  assign unused_inputs = ^{bid, rid, rlast};

  assign mem_ready = (state == IDLE) && aresetn;

  assign awaddr  = addr_q;
  assign araddr  = addr_q;
  assign wdata   = wdata_q;
  assign awid    = '0;
  assign arid    = '0;
  assign awlen   = 8'd0;
  assign arlen   = 8'd0;
  assign awsize  = AX_SIZE;
  assign arsize  = AX_SIZE;
  assign awburst = 2'b01;
  assign arburst = 2'b01;
  assign wstrb   = '1;
  assign wlast   = 1'b1;

  // A channel counts as done once its valid has dropped or it handshakes now
  assign aw_done = !awvalid || awready;
  assign w_done  = !wvalid || wready;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state        <= IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      awvalid      <= 1'b0;
      wvalid       <= 1'b0;
      bready       <= 1'b0;
      arvalid      <= 1'b0;
      rready       <= 1'b0;
      mem_rd_valid <= 1'b0;
      mem_rd_data  <= '0;
      err          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_valid) begin
            addr_q  <= mem_addr;
            wdata_q <= mem_wr_data;
            if (mem_wr) begin
              state   <= WR_REQ;
              awvalid <= 1'b1;
              wvalid  <= 1'b1;
              if (mem_rd) err <= 1'b1;
            end else if (mem_rd) begin
              state   <= RD_REQ;
              arvalid <= 1'b1;
            end else begin
              err <= 1'b1;
            end
          end
        end
        WR_REQ: begin
          if (awvalid && awready) awvalid <= 1'b0;
          if (wvalid && wready) wvalid <= 1'b0;
          if (aw_done && w_done) begin
            state  <= WR_RESP;
            bready <= 1'b1;
          end
        end
        WR_RESP: begin
          if (bvalid) begin
            state  <= IDLE;
            bready <= 1'b0;
            if (bresp != 2'b00) err <= 1'b1;
          end
        end
        RD_REQ: begin
          if (arready) begin
            state   <= RD_DATA;
            arvalid <= 1'b0;
            rready  <= 1'b1;
          end
        end
        RD_DATA: begin
          if (rvalid) begin
            state        <= RD_CPL;
            rready       <= 1'b0;
            mem_rd_data  <= rdata;
            mem_rd_valid <= 1'b1;
            if (rresp != 2'b00) err <= 1'b1;
          end
        end
        RD_CPL: begin
          if (mem_rd_ready) begin
            state        <= IDLE;
            mem_rd_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_driver.sv
// Self-checking bench for memory_driver: a delay-configurable AXI4 slave with its own
// memory, directed sequences, a vector table and a randomized run against a reference memory.
module tb_memory_driver;

  logic        aclk;
  logic        aresetn;
  logic        mem_valid, mem_ready, mem_rd, mem_wr;
  logic [15:0] mem_addr;
  logic [31:0] mem_wr_data;
  logic        mem_rd_valid, mem_rd_ready;
  logic [31:0] mem_rd_data;
  logic        err;
  logic        awvalid, awready;
  logic [15:0] awaddr;
  logic [7:0]  awid, awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        wvalid, wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        bvalid, bready;
  logic [7:0]  bid;
  logic [1:0]  bresp;
  logic        arvalid, arready;
  logic [15:0] araddr;
  logic [7:0]  arid, arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        rvalid, rready;
  logic [7:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;

  memory_driver dut (
    .aclk(aclk), .aresetn(aresetn),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
    .mem_rd_valid(mem_rd_valid), .mem_rd_ready(mem_rd_ready), .mem_rd_data(mem_rd_data),
    .err(err),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid), .awlen(awlen),
    .awsize(awsize), .awburst(awburst),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid), .arlen(arlen),
    .arsize(arsize), .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;

  int aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
  logic [1:0] bresp_cfg = 2'b00;
  logic [1:0] rresp_cfg = 2'b00;

  // Slave: each ready/valid is raised once its channel has waited the configured cycles
  logic [31:0] slave_mem [0:255];
  logic [7:0]  s_waddr, s_raddr;
  logic [31:0] s_wdata;
  int          aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;

  initial begin
    awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
    bid = '0; rid = '0; rlast = 1'b1; bresp = 2'b00; rresp = 2'b00; rdata = '0;
    s_waddr = '0; s_raddr = '0; s_wdata = '0;
    aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
    for (int i = 0; i < 256; i++) slave_mem[i] = '0;
    forever begin
      @(negedge aclk);
      if (awvalid) begin
        awready = (aw_cnt >= aw_delay);
        if (awready) s_waddr = awaddr[7:0];
        aw_cnt++;
      end else begin
        awready = 0; aw_cnt = 0;
      end
      if (wvalid) begin
        wready = (w_cnt >= w_delay);
        if (wready) s_wdata = wdata;
        w_cnt++;
      end else begin
        wready = 0; w_cnt = 0;
      end
      if (bready) begin
        bvalid = (b_cnt >= b_delay);
        if (bvalid) begin
          bresp = bresp_cfg;
          slave_mem[s_waddr] = s_wdata;
        end
        b_cnt++;
      end else begin
        bvalid = 0; b_cnt = 0;
      end
      if (arvalid) begin
        arready = (ar_cnt >= ar_delay);
        if (arready) s_raddr = araddr[7:0];
        ar_cnt++;
      end else begin
        arready = 0; ar_cnt = 0;
      end
      if (rready) begin
        rvalid = (r_cnt >= r_delay);
        if (rvalid) begin
          rdata = slave_mem[s_raddr];
          rresp = rresp_cfg;
        end
        r_cnt++;
      end else begin
        rvalid = 0; r_cnt = 0;
      end
    end
  end

  // Handshake counters and protocol watch (valid dropped early, bready during AW/W)
  int   aw_count = 0, w_count = 0, b_count = 0, ar_count = 0, viol = 0;
  logic aw_pend = 0, w_pend = 0, ar_pend = 0;

  always @(posedge aclk) begin
    if (awvalid && awready) aw_count <= aw_count + 1;
    if (wvalid && wready) w_count <= w_count + 1;
    if (bvalid && bready) b_count <= b_count + 1;
    if (arvalid && arready) ar_count <= ar_count + 1;
    if (!aresetn) begin
      aw_pend <= 0; w_pend <= 0; ar_pend <= 0;
    end else begin
      if ((aw_pend && !awvalid) || (w_pend && !wvalid) || (ar_pend && !arvalid) ||
          (bready && (awvalid || wvalid)))
        viol <= viol + 1;
      aw_pend <= awvalid && !awready;
      w_pend  <= wvalid && !wready;
      ar_pend <= arvalid && !arready;
    end
  end

  typedef struct {
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [31:0] data;
    int          d_aw, d_w, d_b, d_ar, d_r;
    int          hold;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t        vecs[7];
  logic [31:0] ref_mem [0:255];
  logic        ref_err;
  logic [31:0] got, exp_rd;
  logic        prev_rv;
  int          a0, w0, b0, r0, n;

  task automatic step();
    @(negedge aclk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic setDelays(input int a, input int w, input int b, input int ar, input int r);
    aw_delay = a; w_delay = w; b_delay = b; ar_delay = ar; r_delay = r;
  endtask

  task automatic issue(input logic rd, input logic wr, input logic [15:0] addr, input logic [31:0] data);
    mem_valid = 1; mem_rd = rd; mem_wr = wr; mem_addr = addr; mem_wr_data = data;
    step();
    mem_valid = 0; mem_rd = 0; mem_wr = 0;
  endtask

  task automatic waitIdle(input string name);
    int k = 0;
    while (!mem_ready && k < 200) begin
      step();
      k++;
    end
    checkOutput(name, mem_ready, 1);
  endtask

  task automatic applyStimulus(input logic rd, input logic wr, input logic [15:0] addr,
                               input logic [31:0] data, input int hold, output logic [31:0] rd_got);
    int k = 0;
    rd_got = '0;
    issue(rd, wr, addr, data);
    if (rd && !wr) begin
      while (!mem_rd_valid && k < 200) begin
        step();
        k++;
      end
      checkOutput("rd_valid_wait", mem_rd_valid, 1);
      repeat (hold) step();
      rd_got = mem_rd_data;
      mem_rd_ready = 1;
      step();
      mem_rd_ready = 0;
    end
    waitIdle("ready_wait");
  endtask

  initial begin
    aresetn = 0; mem_valid = 0; mem_rd = 0; mem_wr = 0; mem_addr = '0; mem_wr_data = '0;
    mem_rd_ready = 0;
    for (int i = 0; i < 256; i++) ref_mem[i] = '0;

    vecs[0] = '{0, 1, 16'h0040, 32'h01234567, 1, 2, 0, 0, 0, 0, 32'h0};
    vecs[1] = '{1, 0, 16'h0040, 32'h0,        0, 0, 0, 2, 1, 1, 32'h01234567};
    vecs[2] = '{0, 1, 16'h0044, 32'h89ABCDEF, 3, 0, 2, 0, 0, 0, 32'h0};
    vecs[3] = '{0, 1, 16'h0040, 32'h0BADF00D, 0, 3, 1, 0, 0, 0, 32'h0};
    vecs[4] = '{1, 0, 16'h0044, 32'h0,        0, 0, 0, 0, 3, 2, 32'h89ABCDEF};
    vecs[5] = '{1, 0, 16'h0040, 32'h0,        0, 0, 0, 1, 0, 0, 32'h0BADF00D};
    vecs[6] = '{1, 0, 16'h0048, 32'h0,        1, 1, 0, 1, 1, 0, 32'h0};

    repeat (3) step();
    checkOutput("rst_mem_ready_low", mem_ready, 0);
    aresetn = 1;
    step();
    checkOutput("rst_mem_ready", mem_ready, 1);
    checkOutput("rst_valids", {awvalid, wvalid, arvalid, bready, rready, mem_rd_valid}, 0);
    checkOutput("rst_rd_data", mem_rd_data, 0);
    checkOutput("rst_err", err, 0);
    checkOutput("rst_addr_data", {awaddr, araddr, wdata}, 0);
    checkOutput("const_ax", {awlen, arlen, awsize, arsize, awburst, arburst}, {8'd0, 8'd0, 3'd2, 3'd2, 2'b01, 2'b01});
    checkOutput("const_w", {awid, arid, wstrb, wlast}, {8'd0, 8'd0, 4'hF, 1'b1});

    // Zero-wait write latency
    setDelays(0, 0, 0, 0, 0);
    issue(0, 1, 16'h0010, 32'hDEADBEEF);
    checkOutput("wr_c1_valids", {awvalid, wvalid}, 2'b11);
    checkOutput("wr_c1_awaddr", awaddr, 32'h0010);
    checkOutput("wr_c1_wdata", wdata, 32'hDEADBEEF);
    checkOutput("wr_c1_strb_last", {wstrb, wlast}, 5'h1F);
    checkOutput("wr_c1_ready", mem_ready, 0);
    step();
    checkOutput("wr_c2_bready", {bready, awvalid, wvalid}, 3'b100);
    checkOutput("wr_c2_ready", mem_ready, 0);
    step();
    checkOutput("wr_c3_ready", mem_ready, 1);
    checkOutput("wr_c3_err", err, 0);

    // Read with R stalled 5 cycles and completion held off 3 cycles
    applyStimulus(0, 1, 16'h0020, 32'h12345678, 0, got);
    setDelays(0, 0, 0, 0, 5);
    issue(1, 0, 16'h0020, 32'h0);
    prev_rv = 0;
    n = 0;
    while (!mem_rd_valid && n < 200) begin
      prev_rv = rvalid;
      step();
      n++;
    end
    checkOutput("rd_valid_rise", mem_rd_valid, 1);
    checkOutput("rd_valid_after_rvalid", prev_rv, 1);
    checkOutput("rd_data", mem_rd_data, 32'h12345678);
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput("rd_hold", {mem_rd_valid, mem_ready, mem_rd_data}, {1'b1, 1'b0, 32'h12345678});
    end
    mem_rd_ready = 1;
    step();
    mem_rd_ready = 0;
    checkOutput("rd_idle", {mem_ready, mem_rd_valid}, 2'b10);
    checkOutput("rd_data_kept", mem_rd_data, 32'h12345678);

    // W handshakes 4 cycles before AW
    setDelays(4, 0, 0, 0, 0);
    a0 = aw_count; w0 = w_count; b0 = b_count;
    issue(0, 1, 16'h0030, 32'h55AA55AA);
    step();
    checkOutput("split_c2", {wvalid, awvalid, bready}, 3'b010);
    checkOutput("split_w_once", w_count - w0, 1);
    waitIdle("split_idle");
    checkOutput("split_counts", {8'(aw_count - a0), 8'(w_count - w0), 8'(b_count - b0)}, 24'h010101);
    checkOutput("split_err", err, 0);

    // Vector table with mixed back-pressure
    for (int i = 0; i < 7; i++) begin
      setDelays(vecs[i].d_aw, vecs[i].d_w, vecs[i].d_b, vecs[i].d_ar, vecs[i].d_r);
      applyStimulus(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].hold, got);
      if (vecs[i].rd) checkOutput($sformatf("vec%0d_data", i), got, vecs[i].exp_rd);
      checkOutput($sformatf("vec%0d_err", i), err, 0);
    end
    setDelays(0, 0, 0, 0, 0);

    // SLVERR on write; err survives a clean read
    bresp_cfg = 2'b10;
    applyStimulus(0, 1, 16'h0050, 32'hFEEDFACE, 0, got);
    bresp_cfg = 2'b00;
    checkOutput("slverr_err", err, 1);
    applyStimulus(1, 0, 16'h0050, 32'h0, 0, got);
    checkOutput("slverr_read", got, 32'hFEEDFACE);
    checkOutput("slverr_sticky", err, 1);

    // Both rd and wr, then neither
    a0 = aw_count; r0 = ar_count;
    applyStimulus(1, 1, 16'h0060, 32'hA5A5A5A5, 0, got);
    checkOutput("both_counts", {8'(aw_count - a0), 8'(ar_count - r0)}, 16'h0100);
    a0 = aw_count; w0 = w_count; r0 = ar_count;
    issue(0, 0, 16'h0064, 32'h0);
    checkOutput("none_ready", mem_ready, 1);
    checkOutput("none_valids", {awvalid, wvalid, arvalid}, 0);
    step();
    checkOutput("none_counts", {8'(aw_count - a0), 8'(w_count - w0), 8'(ar_count - r0)}, 0);
    checkOutput("none_err", err, 1);

    // Reset in the middle of a write request
    setDelays(20, 20, 0, 0, 0);
    issue(0, 1, 16'h0070, 32'h77777777);
    checkOutput("mid_pre", {awvalid, wvalid}, 2'b11);
    aresetn = 0;
    #1;
    checkOutput("mid_async_drop", {awvalid, wvalid, mem_ready}, 0);
    step();
    step();
    aresetn = 1;
    setDelays(0, 0, 0, 0, 0);
    step();
    checkOutput("mid_after_ready", mem_ready, 1);
    checkOutput("mid_after_rd_data", mem_rd_data, 0);
    checkOutput("mid_after_err", err, 0);

    // Randomized traffic against the reference memory
    ref_err = 0;
    for (int t = 0; t < 40; t++) begin
      int   op;
      logic rd, wr;
      logic [15:0] addr;
      logic [31:0] data;
      op   = $urandom_range(0, 9);
      wr   = (op <= 3) || (op == 8);
      rd   = (op >= 4 && op <= 8);
      addr = 16'h0080 + 16'($urandom_range(0, 127));
      data = $urandom;
      setDelays($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 3), $urandom_range(0, 3));
      bresp_cfg = ($urandom_range(0, 7) == 0) ? 2'b10 : 2'b00;
      rresp_cfg = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'b00;
      exp_rd = ref_mem[addr[7:0]];
      if (!rd && !wr) ref_err = 1;
      if (rd && wr) ref_err = 1;
      if (wr && bresp_cfg != 2'b00) ref_err = 1;
      if (rd && !wr && rresp_cfg != 2'b00) ref_err = 1;
      if (wr) ref_mem[addr[7:0]] = data;
      applyStimulus(rd, wr, addr, data, $urandom_range(0, 3), got);
      if (rd && !wr) checkOutput($sformatf("rand%0d_data", t), got, exp_rd);
      checkOutput($sformatf("rand%0d_err", t), err, ref_err);
    end
    bresp_cfg = 2'b00;
    rresp_cfg = 2'b00;

    checkOutput("protocol_violations", viol, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
